multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier.sv | 80 ++++++++
 tb/tb_multiplier.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multiplier.sv
// multiplier: sequential shift-add unsigned multiplier, one bit per cycle.
//   clk, rst (sync, active-high); init starts an op from IDLE;
//   in_A/in_B captured at start; product holds the last result;
//   busy high during the op; done strobes one cycle at completion.
module multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [WIDTH-1:0]   in_A,
  input  logic [WIDTH-1:0]   in_B,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a, hi, lo, a_n, hi_n, lo_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2*WIDTH-1:0] product_n;
  logic busy_n, done_n;
  logic [WIDTH:0] sum;
  // sum is the 17-bit {carry, hi}; shifting {sum, lo} right keeps the carry
  always_comb begin
    sum       = {1'b0, hi} + {1'b0, lo[0] ? a : '0};
    state_n   = state;
    a_n       = a;
    hi_n      = hi;
    lo_n      = lo;
    cnt_n     = cnt;
    product_n = product;
    busy_n    = busy;
    done_n    = 1'b0;
    case (state)
      IDLE: if (init) begin
        state_n = CALC;
        a_n     = in_A;
        hi_n    = '0;
        lo_n    = in_B;
        cnt_n   = '0;
        busy_n  = 1'b1;
      end
      CALC: begin
        hi_n  = sum[WIDTH:1];
        lo_n  = {sum[0], lo[WIDTH-1:1]};
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(WIDTH-1)) begin
          state_n   = DONE;
          product_n = {sum, lo[WIDTH-1:1]};
          done_n    = 1'b1;
          busy_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a       <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      a       <= a_n;
      hi      <= hi_n;
      lo      <= lo_n;
      cnt     <= cnt_n;
      product <= product_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: directed self-checking bench for multiplier.
module tb_multiplier;
  logic clk = 1'b0, rst = 1'b1, init = 1'b0;
  logic [15:0] in_A = '0, in_B = '0;
  logic [31:0] product;
  logic busy, done;
  int vectors = 0, miscompares = 0;

  multiplier #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .init(init), .in_A(in_A), .in_B(in_B),
    .product(product), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pulse init at edge N, then watch edges N+1..N+20. lat is the first edge
  // offset with done high (-1 if none), nd the number of done cycles.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit disturb,
                        output int lat, output int nd, output logic [31:0] p,
                        output logic [31:0] p15, output logic b0, output logic bd);
    lat = -1; nd = 0; p = 'x; p15 = 'x; bd = 'x;
    @(negedge clk);
    in_A = a; in_B = b; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    b0 = busy;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 15) p15 = product;
      if (done) begin
        nd++;
        if (lat < 0) begin lat = k; p = product; bd = busy; end
      end
      if (disturb && k == 5) begin in_A = 16'hFFFF; in_B = 16'hFFFF; init = 1'b1; end
      if (disturb && k == 6) init = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({product, busy, done} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset: product=%h busy=%b done=%b, want 0/0/0", product, busy, done);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({product, busy, done} !== 34'h0) begin
      miscompares++;
      $display("FAIL idle_after_reset: product=%h busy=%b done=%b, want 0/0/0", product, busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, nd; logic [31:0] p, p15; logic b0, bd;
    run_op(16'd3, 16'd5, 1'b0, lat, nd, p, p15, b0, bd);
    vectors++;
    if (b0 !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b want 1", b0); end
    vectors++;
    if (lat !== 16 || nd !== 1) begin
      miscompares++; $display("FAIL basic_latency: lat=%0d ndone=%0d want 16/1", lat, nd);
    end
    vectors++;
    if (p !== 32'h0000000F) begin miscompares++; $display("FAIL basic_product: got %h want 0000000f", p); end
    vectors++;
    if (bd !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_done: got %b want 0", bd); end
  endtask

  task automatic test_max();
    int lat, nd; logic [31:0] p, p15; logic b0, bd;
    run_op(16'hFFFF, 16'hFFFF, 1'b0, lat, nd, p, p15, b0, bd);
    vectors++;
    if (p !== 32'hFFFE0001 || lat !== 16) begin
      miscompares++; $display("FAIL max_ffff: product=%h lat=%0d want fffe0001/16", p, lat);
    end
    run_op(16'h8000, 16'h0002, 1'b0, lat, nd, p, p15, b0, bd);
    vectors++;
    if (p !== 32'h00010000 || lat !== 16) begin
      miscompares++; $display("FAIL max_8000x2: product=%h lat=%0d want 00010000/16", p, lat);
    end
  endtask

  task automatic test_zero();
    int lat, nd; logic [31:0] p, p15; logic b0, bd;
    run_op(16'h0000, 16'h1234, 1'b0, lat, nd, p, p15, b0, bd);
    vectors++;
    if (p15 !== 32'h00010000) begin
      miscompares++; $display("FAIL zero_hold: product at N+15=%h want 00010000", p15);
    end
    vectors++;
    if (p !== 32'h0 || lat !== 16 || nd !== 1) begin
      miscompares++; $display("FAIL zero_product: product=%h lat=%0d ndone=%0d want 0/16/1", p, lat, nd);
    end
  endtask

  task automatic test_ignored();
    int lat, nd; logic [31:0] p, p15; logic b0, bd;
    run_op(16'd7, 16'd9, 1'b1, lat, nd, p, p15, b0, bd);
    vectors++;
    if (p !== 32'd63 || lat !== 16 || nd !== 1) begin
      miscompares++; $display("FAIL ignored_inputs: product=%h lat=%0d ndone=%0d want 0000003f/16/1", p, lat, nd);
    end
  endtask

  task automatic test_mid_reset();
    int lat, nd, seen; logic [31:0] p, p15; logic b0, bd;
    @(negedge clk);
    in_A = 16'd5; in_B = 16'd6; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({product, busy, done} !== 34'h0) begin
      miscompares++;
      $display("FAIL midreset_clear: product=%h busy=%b done=%b want 0/0/0", product, busy, done);
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL midreset_no_done: got %0d strobes want 0", seen); end
    run_op(16'd2, 16'd4, 1'b0, lat, nd, p, p15, b0, bd);
    vectors++;
    if (p !== 32'd8 || lat !== 16) begin
      miscompares++; $display("FAIL midreset_restart: product=%h lat=%0d want 00000008/16", p, lat);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, nd; logic [31:0] p1, p2;
    d1 = -1; d2 = -1; nd = 0; p1 = 'x; p2 = 'x;
    @(negedge clk);
    in_A = 16'h00FF; in_B = 16'h0101; init = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (d1 < 0) begin d1 = k; p1 = product; end
        else if (d2 < 0) begin d2 = k; p2 = product; end
      end
    end
    init = 1'b0;
    vectors++;
    if (d1 !== 16 || d2 !== 34 || nd !== 2) begin
      miscompares++; $display("FAIL b2b_timing: d1=%0d d2=%0d ndone=%0d want 16/34/2", d1, d2, nd);
    end
    vectors++;
    if (p1 !== 32'h0000FFFF || p2 !== 32'h0000FFFF) begin
      miscompares++; $display("FAIL b2b_product: p1=%h p2=%h want 0000ffff", p1, p2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
